// File: rtl/intersection_phase_scheduler.sv
// Two-approach intersection scheduler (NS/EW greens, yellows, all-red clearances, pedestrian walk).
// Optional night flash mode is compiled in with `define NIGHT_FLASH_EN.
module intersection_phase_scheduler #(
  parameter int unsigned GREEN_MIN  = 4,
  parameter int unsigned GREEN_MAX  = 8,
  parameter int unsigned YELLOW_CYC = 2,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned WALK_CYC   = 3,
  parameter int unsigned FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [7:0] seg_ns,
  output logic [7:0] seg_ew,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam logic [7:0] SEG_GREEN  = 8'b01110111;
  localparam logic [7:0] SEG_YELLOW = 8'b01110110;
  localparam logic [7:0] SEG_RED    = 8'b00001110;
  localparam logic [7:0] SEG_BLANK  = 8'b00000000;

  localparam int unsigned FLASH_PER = 2 * FLASH_HALF;
  localparam int unsigned M1 = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
  localparam int unsigned M2 = (M1 > ALLRED_CYC) ? M1 : ALLRED_CYC;
  localparam int unsigned M3 = (M2 > WALK_CYC) ? M2 : WALK_CYC;
  localparam int unsigned M4 = (M3 > FLASH_PER) ? M3 : FLASH_PER;
  localparam int unsigned TW = $clog2(M4 + 1);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  typedef enum logic {DIR_NS, DIR_EW} dir_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  dir_t            next_dir, next_dir_n;
  logic            pending_n;
  logic            flash_req;

`ifdef NIGHT_FLASH_EN
  assign flash_req = night_mode;
`else
  logic unused_night;
  assign unused_night = night_mode;
  assign flash_req    = 1'b0;
`endif

  function automatic logic at_end(input logic [TW-1:0] t, input int unsigned len);
    return t == TW'(len - 1);
  endfunction

  function automatic logic [7:0] seg_for(input state_t s, input logic [TW-1:0] t,
                                         input logic is_ns);
    case (s)
      NS_GREEN:  return is_ns ? SEG_GREEN  : SEG_RED;
      NS_YELLOW: return is_ns ? SEG_YELLOW : SEG_RED;
      EW_GREEN:  return is_ns ? SEG_RED    : SEG_GREEN;
      EW_YELLOW: return is_ns ? SEG_RED    : SEG_YELLOW;
      FLASH:     return (t < TW'(FLASH_HALF)) ? SEG_YELLOW : SEG_BLANK;
      default:   return SEG_RED;
    endcase
  endfunction

  always_comb begin
    state_n    = state;
    timer_n    = timer + 1'b1;
    next_dir_n = next_dir;
    case (state)
      NS_GREEN:
        if (at_end(timer, GREEN_MAX) ||
            (timer >= TW'(GREEN_MIN - 1) && (ew_car || ped_pending))) begin
          state_n = NS_YELLOW;
          timer_n = '0;
        end
      NS_YELLOW:
        if (at_end(timer, YELLOW_CYC)) begin
          state_n = ALLRED_A;
          timer_n = '0;
        end
      ALLRED_A:
        if (at_end(timer, ALLRED_CYC)) begin
          next_dir_n = DIR_EW;
          timer_n    = '0;
          state_n    = flash_req ? FLASH : (ped_pending ? PED_WALK : EW_GREEN);
        end
      EW_GREEN:
        if (at_end(timer, GREEN_MAX) ||
            (timer >= TW'(GREEN_MIN - 1) && (ns_car || ped_pending))) begin
          state_n = EW_YELLOW;
          timer_n = '0;
        end
      EW_YELLOW:
        if (at_end(timer, YELLOW_CYC)) begin
          state_n = ALLRED_B;
          timer_n = '0;
        end
      ALLRED_B:
        if (at_end(timer, ALLRED_CYC)) begin
          next_dir_n = DIR_NS;
          timer_n    = '0;
          state_n    = flash_req ? FLASH : (ped_pending ? PED_WALK : NS_GREEN);
        end
      PED_WALK:
        if (at_end(timer, WALK_CYC)) begin
          state_n = (next_dir == DIR_NS) ? NS_GREEN : EW_GREEN;
          timer_n = '0;
        end
      FLASH:
        // Each YELLOW+BLANK period restarts the timer; leave only at a period boundary.
        if (at_end(timer, FLASH_PER)) begin
          timer_n = '0;
          if (!flash_req) state_n = ALLRED_B;
        end
      default: begin
        state_n = ALLRED_B;
        timer_n = '0;
      end
    endcase

    if (state_n == PED_WALK && state != PED_WALK) pending_n = 1'b0;
    else if (ped_req && state != PED_WALK)        pending_n = 1'b1;
    else                                          pending_n = ped_pending;
  end

  // Outputs are registered from the next-state values so they track the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ALLRED_B;
      timer       <= '0;
      next_dir    <= DIR_NS;
      ped_pending <= 1'b0;
      seg_ns      <= SEG_RED;
      seg_ew      <= SEG_RED;
      walk        <= 1'b0;
      phase       <= 3'd5;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      next_dir    <= next_dir_n;
      ped_pending <= pending_n;
      seg_ns      <= seg_for(state_n, timer_n, 1'b1);
      seg_ew      <= seg_for(state_n, timer_n, 1'b0);
      walk        <= (state_n == PED_WALK);
      phase       <= state_n;
    end
  end

endmodule
